tree_ni_injector: RTL and testbench

- Endpoint-side injection network interface for the multi-layer tree NoC.
- Accepts packet descriptors and body words from a core, computes the tree destination address and segments the packet into header/body/tail flits.
- Issues flits into one endpoint channel of the tree fabric under per-VC credit flow control.
- Sits directly upstream of a leaf router port; one instance per endpoint.

---
 rtl/pronoc_pkg.sv | 46 ++++
 rtl/ni_credit_counter.sv | 33 +++
 rtl/tree_ni_injector.sv | 171 +++++++++++++++++
 tb/tb_tree_ni_injector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pronoc_pkg.sv
// Shared definitions for the tree NoC endpoint interface: address encoding,
// header field placement, flit flags and the injector FSM states.
package pronoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HDR_WAIT = 2'd1,
    ST_BODY     = 2'd2
  } ni_state_e;

  typedef struct packed {
    logic hdr;
    logic tail;
  } flit_flag_t;

  localparam flit_flag_t FLG_NONE     = '{hdr: 1'b0, tail: 1'b0};
  localparam flit_flag_t FLG_HDR      = '{hdr: 1'b1, tail: 1'b0};
  localparam flit_flag_t FLG_TAIL     = '{hdr: 1'b0, tail: 1'b1};
  localparam flit_flag_t FLG_HDR_TAIL = '{hdr: 1'b1, tail: 1'b1};

  // Header layout: [DAw-1:0] dst, then src, then packet length.
  function automatic int hdr_src_lsb(input int daw);
    return daw;
  endfunction

  function automatic int hdr_len_lsb(input int daw);
    return 2 * daw;
  endfunction

  // Base-k digits of ep, digit i packed at bits [i*kw +: kw].
  function automatic logic [31:0] tree_addr_encode(input int ep, input int k,
                                                   input int l, input int kw);
    logic [31:0] addr;
    int          rem;
    int          digit;
    addr = '0;
    rem  = ep;
    for (int i = 0; i < l; i++) begin
      digit = rem % k;
      rem   = rem / k;
      addr  = addr | (32'(digit & ((1 << kw) - 1)) << (i * kw));
    end
    return addr;
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Single-VC credit counter: starts full at B, saturates at B on an excess
// return and remembers that overflow until reset.
module ni_credit_counter #(
  parameter int B  = 4,
  parameter int Cw = $clog2(B + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_ovf
);

  logic [Cw-1:0] r_cnt;
  logic          r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= Cw'(B);
      r_ovf <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt == Cw'(B)) r_ovf <= 1'b1;
      else                 r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/tree_ni_injector.sv
// Endpoint injection NI: turns a descriptor plus body words into header/body/tail
// flits for one tree-fabric channel under per-VC credit flow control.
module tree_ni_injector
  import pronoc_pkg::*;
#(
  parameter int NE     = 8,
  parameter int K      = 2,
  parameter int L      = 3,
  parameter int V      = 2,
  parameter int B      = 4,
  parameter int Fpay   = 32,
  parameter int MAXLEN = 16,
  parameter int EP_ID  = 0,
  localparam int Kw    = (K > 1) ? $clog2(K) : 1,
  localparam int DAw   = L * Kw,
  localparam int NEw   = $clog2(NE),
  localparam int LENw  = $clog2(MAXLEN + 1),
  localparam int Vw    = (V > 1) ? $clog2(V) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pkt_valid,
  output logic            pkt_ready,
  input  logic [NEw-1:0]  pkt_dst,
  input  logic [LENw-1:0] pkt_len,
  input  logic [Vw-1:0]   pkt_vc,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [Fpay-1:0] dat_in,
  output logic            flit_wr,
  output logic            flit_hdr,
  output logic            flit_tail,
  output logic [Vw-1:0]   flit_vc,
  output logic [Fpay-1:0] flit_data,
  input  logic [V-1:0]    credit_in,
  output logic            pkt_err,
  output logic            cred_err
);

  localparam int HSRC = hdr_src_lsb(DAw);
  localparam int HLEN = hdr_len_lsb(DAw);

  if (Fpay < 2 * DAw + LENw) begin : g_bad_fpay
    $error("tree_ni_injector: Fpay too narrow for the header fields");
  end

  ni_state_e       r_state;
  logic [NEw-1:0]  r_dst;
  logic [LENw-1:0] r_len;
  logic [LENw-1:0] r_rem;
  logic [Vw-1:0]   r_vc;
  logic            r_flit_wr;
  flit_flag_t      r_flags;
  logic [Vw-1:0]   r_flit_vc;
  logic [Fpay-1:0] r_flit_data;
  logic            r_pkt_err;

  logic [V-1:0]    w_zero;
  logic [V-1:0]    w_ovf;
  logic [V-1:0]    w_dec;
  logic            w_dst_bad;
  logic            w_bad;
  logic [NEw-1:0]  w_sel_dst;
  logic [LENw-1:0] w_sel_len;
  logic [Vw-1:0]   w_cur_vc;
  logic            w_cred_ok;
  logic            w_hdr_load;
  logic            w_body_load;
  logic            w_load;
  logic [31:0]     w_dst_enc;
  logic [31:0]     w_src_enc;
  logic [Fpay-1:0] w_hdr;

  // An index wider than NE is only possible when NE is not a power of two.
  if (NE < (1 << NEw)) begin : g_dst_chk
    assign w_dst_bad = (pkt_dst >= NEw'(NE));
  end else begin : g_dst_full
    assign w_dst_bad = 1'b0;
  end

  assign w_bad     = w_dst_bad || (pkt_len == '0);
  assign w_sel_dst = (r_state == ST_IDLE) ? pkt_dst : r_dst;
  assign w_sel_len = (r_state == ST_IDLE) ? pkt_len : r_len;
  assign w_cur_vc  = (r_state == ST_IDLE) ? pkt_vc  : r_vc;
  assign w_cred_ok = !w_zero[w_cur_vc];

  assign pkt_ready   = (r_state == ST_IDLE);
  assign dat_ready   = (r_state == ST_BODY) && w_cred_ok;
  assign w_hdr_load  = ((r_state == ST_IDLE) && pkt_valid && !w_bad && w_cred_ok) ||
                       ((r_state == ST_HDR_WAIT) && w_cred_ok);
  assign w_body_load = dat_valid && dat_ready;
  assign w_load      = w_hdr_load || w_body_load;

  always_comb begin
    w_dst_enc = tree_addr_encode(int'(w_sel_dst), K, L, Kw);
    w_src_enc = tree_addr_encode(EP_ID, K, L, Kw);
    w_hdr = '0;
    w_hdr[DAw-1:0]      = w_dst_enc[DAw-1:0];
    w_hdr[HSRC +: DAw]  = w_src_enc[DAw-1:0];
    w_hdr[HLEN +: LENw] = w_sel_len;
  end

  for (genvar v = 0; v < V; v++) begin : g_vc
    assign w_dec[v] = w_load && (w_cur_vc == Vw'(v));
    ni_credit_counter #(.B(B)) u_cc (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (credit_in[v]),
      .i_dec  (w_dec[v]),
      .o_zero (w_zero[v]),
      .o_ovf  (w_ovf[v])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dst       <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_vc        <= '0;
      r_flit_wr   <= 1'b0;
      r_flags     <= FLG_NONE;
      r_flit_vc   <= '0;
      r_flit_data <= '0;
      r_pkt_err   <= 1'b0;
    end else begin
      r_flit_wr <= w_load;
      r_pkt_err <= (r_state == ST_IDLE) && pkt_valid && w_bad;
      case (r_state)
        ST_IDLE: if (pkt_valid && !w_bad) begin
          r_dst <= pkt_dst;
          r_len <= pkt_len;
          r_vc  <= pkt_vc;
          r_rem <= pkt_len - 1'b1;
          if (!w_cred_ok)                r_state <= ST_HDR_WAIT;
          else if (pkt_len != LENw'(1))  r_state <= ST_BODY;
        end
        ST_HDR_WAIT: if (w_cred_ok) begin
          r_state <= (r_len == LENw'(1)) ? ST_IDLE : ST_BODY;
        end
        ST_BODY: if (w_body_load) begin
          r_rem <= r_rem - 1'b1;
          if (r_rem == LENw'(1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // r_rem counts the body flits still owed, so 1 marks the tail.
      if (w_hdr_load) begin
        r_flags     <= (w_sel_len == LENw'(1)) ? FLG_HDR_TAIL : FLG_HDR;
        r_flit_vc   <= w_cur_vc;
        r_flit_data <= w_hdr;
      end else if (w_body_load) begin
        r_flags     <= (r_rem == LENw'(1)) ? FLG_TAIL : FLG_NONE;
        r_flit_vc   <= r_vc;
        r_flit_data <= dat_in;
      end else begin
        r_flags <= FLG_NONE;
      end
    end
  end

  assign flit_wr   = r_flit_wr;
  assign flit_hdr  = r_flags.hdr;
  assign flit_tail = r_flags.tail;
  assign flit_vc   = r_flit_vc;
  assign flit_data = r_flit_data;
  assign pkt_err   = r_pkt_err;
  assign cred_err  = |w_ovf;

endmodule

// File: tb/tb_tree_ni_injector.sv
// Bench for tree_ni_injector: directed scenarios plus a randomized run against a
// packet-level model with a credit-returning router buffer.
module tb_tree_ni_injector;

  localparam int NE = 8, K = 2, L = 3, V = 2, B = 4, FPAY = 32, MAXLEN = 16, EP_ID = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [2:0]  pkt_dst = '0;
  logic [4:0]  pkt_len = '0;
  logic [0:0]  pkt_vc = '0;
  logic        dat_valid = 1'b0;
  logic        dat_ready;
  logic [31:0] dat_in = '0;
  logic        flit_wr, flit_hdr, flit_tail;
  logic [0:0]  flit_vc;
  logic [31:0] flit_data;
  logic [1:0]  credit_in = '0;
  logic        pkt_err, cred_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        hdr;
    logic        tail;
    logic        vc;
    logic [31:0] data;
  } flit_t;

  tree_ni_injector #(.NE(NE), .K(K), .L(L), .V(V), .B(B), .Fpay(FPAY),
                     .MAXLEN(MAXLEN), .EP_ID(EP_ID)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dst(pkt_dst), .pkt_len(pkt_len), .pkt_vc(pkt_vc),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
    .flit_wr(flit_wr), .flit_hdr(flit_hdr), .flit_tail(flit_tail),
    .flit_vc(flit_vc), .flit_data(flit_data), .credit_in(credit_in),
    .pkt_err(pkt_err), .cred_err(cred_err)
  );

  wire [2:0] cred0 = dut.g_vc[0].u_cc.r_cnt;
  wire [2:0] cred1 = dut.g_vc[1].u_cc.r_cnt;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "timeout");
  end

  // Header word: base-K digits of dst and src, then length at bit 2*L.
  function automatic logic [31:0] exp_hdr(input int dst, input int len);
    int h;
    h = 0;
    for (int i = 0; i < L; i++) begin
      h += ((dst / (K ** i)) % K) * (2 ** i);
      h += ((EP_ID / (K ** i)) % K) * (2 ** (L + i));
    end
    h += len * (2 ** (2 * L));
    return 32'(h);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    checks++; if (flit_wr !== 1'b0) begin errors++; $display("FAIL reset_flit_wr got %b exp 0", flit_wr); end
    checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_pkt_ready got %b exp 1", pkt_ready); end
    checks++; if (dat_ready !== 1'b0) begin errors++; $display("FAIL reset_dat_ready got %b exp 0", dat_ready); end
    checks++; if ({pkt_err, cred_err, flit_hdr, flit_tail} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {pkt_err, cred_err, flit_hdr, flit_tail}); end
    checks++; if (flit_data !== 32'h0 || flit_vc !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b exp 0/0", flit_data, flit_vc); end
    checks++; if (cred0 !== 3'd4 || cred1 !== 3'd4) begin errors++; $display("FAIL reset_credits got %0d/%0d exp 4/4", cred0, cred1); end
  endtask

  task automatic test_single();
    pkt_valid = 1'b1; pkt_dst = 3'd5; pkt_len = 5'd1; pkt_vc = 1'b0;
    tick();
    pkt_valid = 1'b0;
    checks++; if ({flit_wr, flit_hdr, flit_tail, flit_vc} !== 4'b1110) begin errors++; $display("FAIL single_flags got %b exp 1110", {flit_wr, flit_hdr, flit_tail, flit_vc}); end
    checks++; if (flit_data !== exp_hdr(5, 1)) begin errors++; $display("FAIL single_data got %h exp %h", flit_data, exp_hdr(5, 1)); end
    checks++; if (flit_data[9:0] !== 10'b0001_000_101) begin errors++; $display("FAIL single_fields got %b exp 0001000101", flit_data[9:0]); end
    checks++; if (cred0 !== 3'd3) begin errors++; $display("FAIL single_cred got %0d exp 3", cred0); end
    tick();
    checks++; if (flit_wr !== 1'b0 || pkt_ready !== 1'b1) begin errors++; $display("FAIL single_idle got wr=%b rdy=%b exp 0/1", flit_wr, pkt_ready); end
    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    checks++; if (cred0 !== 3'd4) begin errors++; $display("FAIL single_return got %0d exp 4", cred0); end
  endtask

  task automatic test_credit_stall();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    pkt_valid = 1'b1; pkt_dst = 3'd3; pkt_len = 5'd6; pkt_vc = 1'b1;
    dat_valid = 1'b1; dat_in = w[0];
    tick();
    pkt_valid = 1'b0;
    checks++; if ({flit_wr, flit_hdr, flit_tail, flit_vc} !== 4'b1101 || flit_data !== exp_hdr(3, 6)) begin
      errors++; $display("FAIL stall_hdr got %b %h exp 1101 %h", {flit_wr, flit_hdr, flit_tail, flit_vc}, flit_data, exp_hdr(3, 6)); end
    for (int b = 0; b < 3; b++) begin
      tick();
      checks++; if ({flit_wr, flit_hdr, flit_tail, flit_vc} !== 4'b1001 || flit_data !== w[b]) begin
        errors++; $display("FAIL stall_body%0d got %b %h exp 1001 %h", b, {flit_wr, flit_hdr, flit_tail, flit_vc}, flit_data, w[b]); end
      dat_in = w[b + 1];
    end
    checks++; if (dat_ready !== 1'b0 || cred1 !== 3'd0) begin errors++; $display("FAIL stall_block got rdy=%b cred=%0d exp 0/0", dat_ready, cred1); end
    tick();
    checks++; if (flit_wr !== 1'b0) begin errors++; $display("FAIL stall_bubble got %b exp 0", flit_wr); end
    credit_in = 2'b10;
    tick();
    credit_in = 2'b00;
    checks++; if (flit_wr !== 1'b0 || dat_ready !== 1'b1) begin errors++; $display("FAIL stall_resume got wr=%b rdy=%b exp 0/1", flit_wr, dat_ready); end
    tick();
    checks++; if ({flit_wr, flit_tail} !== 2'b10 || flit_data !== w[3]) begin errors++; $display("FAIL stall_one got %b %h exp 10 %h", {flit_wr, flit_tail}, flit_data, w[3]); end
    dat_in = w[4];
    tick();
    checks++; if (flit_wr !== 1'b0) begin errors++; $display("FAIL stall_only_one got %b exp 0", flit_wr); end
    credit_in = 2'b10;
    tick();
    credit_in = 2'b00;
    tick();
    dat_valid = 1'b0;
    checks++; if ({flit_wr, flit_tail} !== 2'b11 || flit_data !== w[4]) begin errors++; $display("FAIL stall_tail got %b %h exp 11 %h", {flit_wr, flit_tail}, flit_data, w[4]); end
    credit_in = 2'b10;
    repeat (4) tick();
    credit_in = 2'b00;
    checks++; if (cred1 !== 3'd4 || pkt_ready !== 1'b1) begin errors++; $display("FAIL stall_restore got cred=%0d rdy=%b exp 4/1", cred1, pkt_ready); end
  endtask

  task automatic test_concurrent();
    logic [31:0] w [5];
    int dst;
    dst = $urandom_range(0, NE - 1);
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    pkt_valid = 1'b1; pkt_dst = 3'(dst); pkt_len = 5'd6; pkt_vc = 1'b1;
    dat_valid = 1'b1; dat_in = w[0];
    tick();
    pkt_valid = 1'b0;
    checks++; if ({flit_wr, flit_hdr} !== 2'b11 || flit_data !== exp_hdr(dst, 6)) begin errors++; $display("FAIL conc_hdr got %b %h exp 11 %h", {flit_wr, flit_hdr}, flit_data, exp_hdr(dst, 6)); end
    for (int b = 0; b < 5; b++) begin
      credit_in = (b < 2) ? 2'b10 : 2'b00;
      tick();
      checks++; if ({flit_wr, flit_hdr, flit_tail} !== {2'b10, b == 4} || flit_data !== w[b]) begin
        errors++; $display("FAIL conc_body%0d got %b %h exp %b %h", b, {flit_wr, flit_hdr, flit_tail}, flit_data, {2'b10, b == 4}, w[b]); end
      checks++; if (int'(cred1) != ((b < 2) ? 3 : 4 - b)) begin errors++; $display("FAIL conc_cred%0d got %0d exp %0d", b, cred1, (b < 2) ? 3 : 4 - b); end
      if (b < 4) dat_in = w[b + 1];
    end
    credit_in = 2'b00; dat_valid = 1'b0;
    credit_in = 2'b10;
    repeat (4) tick();
    credit_in = 2'b00;
    checks++; if (cred1 !== 3'd4) begin errors++; $display("FAIL conc_restore got %0d exp 4", cred1); end
  endtask

  task automatic test_bad_desc();
    pkt_valid = 1'b1; pkt_dst = 3'($urandom_range(0, NE - 1)); pkt_len = 5'd0; pkt_vc = 1'($urandom);
    tick();
    pkt_valid = 1'b0;
    checks++; if ({pkt_err, flit_wr, pkt_ready} !== 3'b101) begin errors++; $display("FAIL bad_pulse got %b exp 101", {pkt_err, flit_wr, pkt_ready}); end
    tick();
    checks++; if ({pkt_err, flit_wr, pkt_ready} !== 3'b001) begin errors++; $display("FAIL bad_after got %b exp 001", {pkt_err, flit_wr, pkt_ready}); end
    checks++; if (cred0 !== 3'd4 || cred1 !== 3'd4) begin errors++; $display("FAIL bad_credits got %0d/%0d exp 4/4", cred0, cred1); end
  endtask

  task automatic test_random();
    flit_t expq[$];
    flit_t got, e;
    int occ [2];
    int pkts_left, words_left, cyc, cur_len, cur_dst;
    bit desc_active, acc, dacc, exp_err;
    logic cur_vc;
    logic [31:0] sent;
    occ[0] = 0; occ[1] = 0;
    pkts_left = 60; words_left = 0; cyc = 0; desc_active = 0;
    cur_len = 0; cur_dst = 0; cur_vc = 1'b0;
    while ((pkts_left > 0 || desc_active || expq.size() > 0) && cyc < 6000) begin
      cyc++;
      if (!desc_active && pkts_left > 0 && $urandom_range(0, 2) != 0) begin
        cur_dst = $urandom_range(0, NE - 1);
        cur_len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAXLEN);
        cur_vc = 1'($urandom);
        pkt_dst = 3'(cur_dst); pkt_len = 5'(cur_len); pkt_vc = cur_vc;
        pkt_valid = 1'b1; desc_active = 1;
      end
      dat_valid = (words_left > 0) && ($urandom_range(0, 3) != 0);
      dat_in = $urandom;
      sent = dat_in;
      for (int v = 0; v < 2; v++) begin
        credit_in[v] = (occ[v] > 0) && ($urandom_range(0, 1) == 1);
        if (credit_in[v]) occ[v]--;
      end
      acc = pkt_valid && pkt_ready;
      dacc = dat_valid && dat_ready;
      tick();
      exp_err = acc && (cur_len == 0);
      if (acc) begin
        pkt_valid = 1'b0; pkts_left--;
        if (cur_len == 0) desc_active = 0;
        else begin
          expq.push_back('{hdr: 1'b1, tail: cur_len == 1, vc: cur_vc, data: exp_hdr(cur_dst, cur_len)});
          words_left = cur_len - 1;
          if (cur_len == 1) desc_active = 0;
        end
      end
      if (dacc) begin
        words_left--;
        expq.push_back('{hdr: 1'b0, tail: words_left == 0, vc: cur_vc, data: sent});
        if (words_left == 0) desc_active = 0;
      end
      checks++; if (pkt_err !== exp_err) begin errors++; $display("FAIL rnd_pkt_err cyc %0d got %b exp %b", cyc, pkt_err, exp_err); end
      if (flit_wr === 1'b1) begin
        got = '{hdr: flit_hdr, tail: flit_tail, vc: flit_vc, data: flit_data};
        occ[flit_vc]++;
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL rnd_extra cyc %0d got %h exp none", cyc, got); end
        else begin
          e = expq.pop_front();
          if (got !== e) begin errors++; $display("FAIL rnd_flit cyc %0d got %h exp %h", cyc, got, e); end
        end
        checks++; if (occ[flit_vc] > B) begin errors++; $display("FAIL rnd_overrun vc %0d got %0d exp <=%0d", flit_vc, occ[flit_vc], B); end
      end
      checks++; if (int'(cred0) != B - occ[0] || int'(cred1) != B - occ[1]) begin
        errors++; $display("FAIL rnd_cred cyc %0d got %0d/%0d exp %0d/%0d", cyc, cred0, cred1, B - occ[0], B - occ[1]); end
    end
    dat_valid = 1'b0; pkt_valid = 1'b0;
    checks++; if (cyc >= 6000 || expq.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", expq.size()); end
    for (int i = 0; i < B + 1; i++) begin
      credit_in = {occ[1] > 0, occ[0] > 0};
      if (occ[0] > 0) occ[0]--;
      if (occ[1] > 0) occ[1]--;
      tick();
    end
    credit_in = 2'b00;
    checks++; if (cred0 !== 3'd4 || cred1 !== 3'd4) begin errors++; $display("FAIL rnd_restore got %0d/%0d exp 4/4", cred0, cred1); end
  endtask

  task automatic test_overflow();
    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    checks++; if (cred_err !== 1'b1 || cred0 !== 3'd4) begin errors++; $display("FAIL ovf_set got err=%b cred=%0d exp 1/4", cred_err, cred0); end
    repeat (3) tick();
    checks++; if (cred_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", cred_err); end
  endtask

  task automatic test_reset_mid();
    pkt_valid = 1'b1; pkt_dst = 3'($urandom_range(0, NE - 1)); pkt_len = 5'd6; pkt_vc = 1'b0;
    dat_valid = 1'b1; dat_in = $urandom;
    tick();
    pkt_valid = 1'b0;
    repeat (2) tick();
    checks++; if (flit_wr !== 1'b1 || dat_ready !== 1'b1) begin errors++; $display("FAIL mid_setup got wr=%b rdy=%b exp 1/1", flit_wr, dat_ready); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({flit_wr, flit_hdr, flit_tail, pkt_err, cred_err} !== 5'b0 || flit_data !== 32'h0) begin
      errors++; $display("FAIL mid_clear got %b %h exp 00000 0", {flit_wr, flit_hdr, flit_tail, pkt_err, cred_err}, flit_data); end
    dat_valid = 1'b0;
    tick();
    #3 reset = 1'b1;
    tick();
    checks++; if (cred0 !== 3'd4 || cred1 !== 3'd4 || pkt_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after got %0d/%0d rdy=%b exp 4/4/1", cred0, cred1, pkt_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (flit_wr !== 1'b0) begin errors++; $display("FAIL mid_no_tail%0d got %b exp 0", i, flit_wr); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_stall();
    test_concurrent();
    test_bad_desc();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
